// File: rtl/lane_dly_tap_ctrl_if.sv
// Request handshake between the training fabric and the delay-tap sequencer.
// The fabric side drives the request; the sequencer answers with REQ_READY.
interface lane_dly_tap_ctrl_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_SEL;
  logic       REQ_DIR;
  logic       REQ_LOAD;
  logic [7:0] REQ_COUNT;

  modport master (
    output REQ_VALID, REQ_SEL, REQ_DIR, REQ_LOAD, REQ_COUNT,
    input  REQ_READY
  );

  modport slave (
    input  REQ_VALID, REQ_SEL, REQ_DIR, REQ_LOAD, REQ_COUNT,
    output REQ_READY
  );
endinterface

// File: rtl/lane_dly_tap_ctrl.sv
// Frames DQS delay-line MOVE/LOAD pulses inside a clock-pause window and keeps shadow taps.
// First pulse PAUSE_SETUP+1 cycles after accept; REQ_READY low from accept until after DONE.
module lane_dly_tap_ctrl #(
  parameter int         PAUSE_SETUP = 4,
  parameter int         MOVE_GAP    = 2,
  parameter int         PAUSE_HOLD  = 4,
  parameter logic [7:0] RX_TAP_INIT = 8'd1,
  parameter logic [7:0] TX_TAP_INIT = 8'd1
) (
  input  logic                 FAB_CLK,
  input  logic                 ARST_N,
  lane_dly_tap_ctrl_if.slave   req,
  input  logic                 RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic                 TX_DELAY_LINE_OUT_OF_RANGE,
  output logic                 DELAY_LINE_SEL,
  output logic                 DELAY_LINE_DIRECTION,
  output logic                 DELAY_LINE_MOVE,
  output logic                 DELAY_LINE_LOAD,
  output logic                 HS_IO_CLK_PAUSE,
  output logic                 DONE,
  output logic                 STATUS_OOR,
  output logic [7:0]           TAPS_MOVED,
  output logic [7:0]           RX_TAP,
  output logic [7:0]           TX_TAP
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_HOLD, S_DONE
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] rem_q;
  logic       sel_q, dir_q, load_q;
  logic       ready_q, pause_q, move_q, ld_q, dsel_q, ddir_q, done_q, oor_q;
  logic [7:0] taps_q, rx_q, tx_q;

  logic       oor_d, end_op_d, fire_d;
  logic [7:0] tap_cur, tap_d;

  always_comb begin
    oor_d    = oor_q | ((state_q == S_GAP) &
               (sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE));
    end_op_d = oor_d | (rem_q == 8'd0) | load_q;
    // A pulse is launched on the last SETUP cycle or on the last GAP cycle when more taps remain.
    fire_d   = ((state_q == S_SETUP) & (cnt_q == 4'd0)) |
               ((state_q == S_GAP) & (cnt_q == 4'd0) & ~end_op_d);
    tap_cur  = sel_q ? tx_q : rx_q;
    if (load_q)
      tap_d = sel_q ? TX_TAP_INIT : RX_TAP_INIT;
    else if (dir_q)
      tap_d = (tap_cur == 8'hFF) ? tap_cur : tap_cur + 8'd1;
    else
      tap_d = (tap_cur == 8'h00) ? tap_cur : tap_cur - 8'd1;
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rem_q   <= 8'd0;
      sel_q   <= 1'b0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      ready_q <= 1'b1;
      pause_q <= 1'b0;
      move_q  <= 1'b0;
      ld_q    <= 1'b0;
      dsel_q  <= 1'b0;
      ddir_q  <= 1'b0;
      done_q  <= 1'b0;
      oor_q   <= 1'b0;
      taps_q  <= 8'd0;
      rx_q    <= RX_TAP_INIT;
      tx_q    <= TX_TAP_INIT;
    end else begin
      oor_q <= oor_d;
      if (fire_d) begin
        move_q <= ~load_q;
        ld_q   <= load_q;
        taps_q <= taps_q + 8'd1;
        rem_q  <= rem_q - 8'd1;
        if (sel_q) tx_q <= tap_d;
        else       rx_q <= tap_d;
      end else begin
        move_q <= 1'b0;
        ld_q   <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (req.REQ_VALID && ready_q) begin
            sel_q   <= req.REQ_SEL;
            dir_q   <= req.REQ_DIR;
            load_q  <= req.REQ_LOAD;
            rem_q   <= req.REQ_COUNT;
            oor_q   <= 1'b0;
            taps_q  <= 8'd0;
            ready_q <= 1'b0;
            if (!req.REQ_LOAD && req.REQ_COUNT == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SETUP;
              pause_q <= 1'b1;
              dsel_q  <= req.REQ_SEL;
              ddir_q  <= req.REQ_DIR & ~req.REQ_LOAD;
              cnt_q   <= 4'(PAUSE_SETUP - 1);
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == 4'd0) state_q <= S_PULSE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_PULSE: begin
          state_q <= S_GAP;
          cnt_q   <= 4'(MOVE_GAP - 1);
        end
        S_GAP: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (end_op_d) begin
            pause_q <= 1'b0;
            if (PAUSE_HOLD == 0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_HOLD;
              cnt_q   <= 4'(PAUSE_HOLD - 1);
            end
          end else begin
            state_q <= S_PULSE;
          end
        end
        S_HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          dsel_q  <= 1'b0;
          ddir_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req.REQ_READY         = ready_q;
  assign DELAY_LINE_SEL        = dsel_q;
  assign DELAY_LINE_DIRECTION  = ddir_q;
  assign DELAY_LINE_MOVE       = move_q;
  assign DELAY_LINE_LOAD       = ld_q;
  assign HS_IO_CLK_PAUSE       = pause_q;
  assign DONE                  = done_q;
  assign STATUS_OOR            = oor_q;
  assign TAPS_MOVED            = taps_q;
  assign RX_TAP                = rx_q;
  assign TX_TAP                = tx_q;

endmodule

// File: doc/lane_dly_tap_ctrl.md
# lane_dly_tap_ctrl

Sequencer directly upstream of the DDR4 PHY lane controller's delay-line and clock-pause inputs. It takes tap-adjust or reload requests from the training fabric through a valid/ready handshake. For each request it frames the adjustment inside an HS_IO_CLK_PAUSE window, issues spaced single-cycle MOVE or LOAD pulses, and aborts on out-of-range. It keeps a shadow tap position for the RX and TX DQS delay lines so training logic can read the current setting without querying the PHY.

## Interface
- PAUSE_SETUP, 4: cycles of pause asserted before the first pulse, range 1..15.
- MOVE_GAP, 2: idle cycles after every MOVE/LOAD pulse, range 1..15.
- PAUSE_HOLD, 4: cycles after pause release before DONE, range 0..15.
- RX_TAP_INIT, 8'd1: RX shadow tap value at reset and on LOAD.
- TX_TAP_INIT, 8'd1: TX shadow tap value at reset and on LOAD.

Ports:
- FAB_CLK  in  1  fabric clock; only clock.
- ARST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  high only in IDLE.
- REQ_SEL  in  1  0 = RX DQS line, 1 = TX DQS line.
- REQ_DIR  in  1  1 = increment, 0 = decrement.
- REQ_LOAD  in  1  reload init value; REQ_COUNT and REQ_DIR ignored.
- REQ_COUNT  in  8  number of taps to move.
- RX_DELAY_LINE_OUT_OF_RANGE  in  1  lane controller flag.
- TX_DELAY_LINE_OUT_OF_RANGE  in  1  lane controller flag.
- DELAY_LINE_SEL, DELAY_LINE_DIRECTION  out  1 each  held for the whole operation.
- DELAY_LINE_MOVE, DELAY_LINE_LOAD  out  1 each  single-cycle pulses.
- HS_IO_CLK_PAUSE  out  1  pause window.
- DONE  out  1  single-cycle completion pulse.
- STATUS_OOR  out  1  sticky abort flag; cleared on next accept.
- TAPS_MOVED  out  8  pulses issued in the last operation.
- RX_TAP, TX_TAP  out  8 each  shadow tap positions.

## Operation
- States: IDLE, SETUP, PULSE, GAP, RELEASE/HOLD, DONE.
- Accept: REQ_VALID & REQ_READY in IDLE latches SEL, DIR, LOAD and COUNT, and clears STATUS_OOR and TAPS_MOVED.
- Zero request (COUNT = 0 and LOAD = 0) goes straight to DONE. No pause and no pulse are issued.
- SETUP: HS_IO_CLK_PAUSE = 1 for PAUSE_SETUP cycles. DELAY_LINE_SEL and DELAY_LINE_DIRECTION are driven from the latched request.
- PULSE: one cycle of DELAY_LINE_MOVE, or of DELAY_LINE_LOAD for a LOAD request. TAPS_MOVED increments and the remaining count decrements.
- Shadow tap update for the selected line:
  - MOVE with DIR = 1: +1, saturating at 255.
  - MOVE with DIR = 0: −1, saturating at 0.
  - LOAD: set to the init value.
- GAP: MOVE_GAP cycles. The selected line's OUT_OF_RANGE flag is sampled every GAP cycle; if seen high, STATUS_OOR sets.
- At the end of GAP:
  - If STATUS_OOR is set, or remaining = 0, or the request is LOAD, go to RELEASE.
  - Otherwise go to PULSE.
- RELEASE/HOLD: pause = 0 for PAUSE_HOLD cycles. SEL and DIR stay held.
- DONE: one cycle, then IDLE.
- REQ_VALID outside IDLE is ignored; it is not queued.
- The non-selected line's OUT_OF_RANGE flag is ignored.

## Timing
- Reset values: REQ_READY = 1; RX_TAP = RX_TAP_INIT; TX_TAP = TX_TAP_INIT; all other outputs 0.
- Reset asserted mid-operation drops pause and pulses asynchronously and returns to IDLE with no DONE pulse.
- Cycle 0 is the accept cycle. For an N-tap MOVE request, with S = PAUSE_SETUP, G = MOVE_GAP, H = PAUSE_HOLD:
  - Pause high on cycles 1 .. S+N(G+1).
  - MOVE pulses at cycles S+1+k(G+1), for k = 0..N−1.
  - Pause low from cycle S+N(G+1)+1.
  - DONE at cycle S+N(G+1)+H+1.
  - REQ_READY = 1 from the following cycle.
- LOAD request: same timing as N = 1.
- OOR abort after pulse j (1-based): the timing above applies with N = j; TAPS_MOVED = j.
- Zero request: DONE at cycle 1, REQ_READY at cycle 2.
- All outputs are registered.
- Shadow taps update in the same cycle the MOVE/LOAD pulse is visible.

## Test plan
- Reset, then REQ SEL = 0, DIR = 1, COUNT = 3 at defaults:
  - Pause on cycles 1–13; MOVE at 5, 8, 11; DONE at 18.
  - RX_TAP = 4, TAPS_MOVED = 3, TX_TAP unchanged at 1.
- TX, DIR = 0, COUNT = 5 from TX_TAP = 1: TX_TAP saturates at 0 and TAPS_MOVED = 5.
- TX_DELAY_LINE_OUT_OF_RANGE raised during the gap after the 2nd pulse of a COUNT = 6 TX request:
  - Only 2 MOVE pulses; STATUS_OOR = 1; TAPS_MOVED = 2; DONE at 4+6+4+1 = 15.
  - RX_DELAY_LINE_OUT_OF_RANGE raised during an RX request of the same shape produces the same result.
- LOAD with RX_TAP = 9: one LOAD pulse at cycle 5, no MOVE, RX_TAP = 1, DONE at cycle 12.
- COUNT = 0 request: no pause and no pulse; DONE at cycle 1. REQ_VALID held during a busy operation is not accepted until REQ_READY returns.
- ARST_N low at cycle 7 of an active request: pause drops immediately and no DONE is produced. After release, REQ_READY = 1 and the shadow taps are back at their init values.
